// File: rtl/deserializer.sv
// Serial-to-parallel receiver: rebuilds an MSB-first bit stream into a parallel word.
// Each burst produces one single-cycle strobe. The burst length is reported in the
// serializer's encoding, where 0 stands for a full word. Bursts shorter than MIN_LEN
// are dropped.
module deserializer #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = 4,
  parameter int MIN_LEN        = 3
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o,
  output logic                      busy_o
);

  // Counter is one bit wider than the length field so it can reach DATA_BUS_WIDTH.
  localparam int                      CW       = DATA_MOD_WIDTH + 1;
  localparam logic [CW-1:0]           FULL_M1  = CW'(DATA_BUS_WIDTH - 1);
  localparam logic [CW-1:0]           MIN_CNT  = CW'(MIN_LEN);
  localparam logic [DATA_MOD_WIDTH-1:0] TOP_IDX = DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1);

  typedef enum logic {IDLE_S, RECV_S} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [DATA_BUS_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_BUS_WIDTH-1:0]   data_q, data_d;
  logic [DATA_MOD_WIDTH-1:0]   mod_q, mod_d;
  logic                        val_q, val_d;

  logic [DATA_MOD_WIDTH-1:0]   bit_idx;
  logic [DATA_BUS_WIDTH-1:0]   shift_with_bit;
  logic                        word_done;

  // State register.
  always_ff @(posedge clk_i) begin
    if (srst_i) state_q <= IDLE_S;
    else        state_q <= state_d;
  end

  // Datapath registers; outputs are cleared by reset along with the partial word.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
    end
  end

  // Next-state: a valid bit opens a burst, a missing valid closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_S:  if (ser_data_val_i)  state_d = RECV_S;
      RECV_S:  if (!ser_data_val_i) state_d = IDLE_S;
      default: state_d = IDLE_S;
    endcase
  end

  // Bit placement, word completion and end-of-burst delivery.
  always_comb begin
    // cnt_q is 0 in IDLE_S, so the first bit naturally lands at the MSB.
    bit_idx                 = TOP_IDX - cnt_q[DATA_MOD_WIDTH-1:0];
    shift_with_bit          = shift_q;
    shift_with_bit[bit_idx] = ser_data_i;
    word_done               = ser_data_val_i && (cnt_q == FULL_M1);

    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;

    if (ser_data_val_i) begin
      shift_d = shift_with_bit;
      cnt_d   = cnt_q + 1'b1;
      if (word_done) begin
        // Full word: deliver it and restart at the MSB with no gap.
        data_d  = shift_with_bit;
        mod_d   = '0;
        val_d   = 1'b1;
        cnt_d   = '0;
        shift_d = '0;
      end
    end else begin
      if ((state_q == RECV_S) && (cnt_q != '0) && (cnt_q >= MIN_CNT)) begin
        data_d = shift_q;
        mod_d  = cnt_q[DATA_MOD_WIDTH-1:0];
        val_d  = 1'b1;
      end
      cnt_d   = '0;
      shift_d = '0;
    end
  end

  // Output decode.
  always_comb begin
    deser_data_o     = data_q;
    deser_data_mod_o = mod_q;
    deser_data_val_o = val_q;
    busy_o           = (state_q == RECV_S) && (cnt_q != '0);
  end

endmodule

// File: tb/tb_deserializer.sv
// Testbench for deserializer: a scoreboard of expected strobes, filled from a
// burst-level model, checked by an independent monitor.
module tb_deserializer;
  localparam int W  = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          srst;
  logic          sd;
  logic          sv;
  logic [W-1:0]  data_o;
  logic [MW-1:0] mod_o;
  logic          val_o;
  logic          busy_o;

  deserializer #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(MW), .MIN_LEN(3)) dut (
    .clk_i            (clk),
    .srst_i           (srst),
    .ser_data_i       (sd),
    .ser_data_val_i   (sv),
    .deser_data_o     (data_o),
    .deser_data_mod_o (mod_o),
    .deser_data_val_o (val_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  d;
    logic [MW-1:0] m;
    int            c;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [W-1:0]  hold_d = '0;
  logic [MW-1:0] hold_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard, including its cycle;
  // between strobes the outputs must hold the last delivered values.
  always @(negedge clk) begin
    if (!srst) begin
      n_cmp++;
      if (val_o) begin
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL strobe_unexpected: data=%h mod=%0d cycle=%0d", data_o, mod_o, cyc);
          hold_d = data_o;
          hold_m = mod_o;
        end else begin
          e = sb.pop_front();
          if (data_o !== e.d || mod_o !== e.m || cyc != e.c) begin
            n_bad++;
            $display("FAIL strobe: data=%h mod=%0d cycle=%0d expected data=%h mod=%0d cycle=%0d",
                     data_o, mod_o, cyc, e.d, e.m, e.c);
          end
          hold_d = e.d;
          hold_m = e.m;
        end
      end else if (data_o !== hold_d || mod_o !== hold_m) begin
        n_bad++;
        $display("FAIL hold: data=%h mod=%0d expected data=%h mod=%0d", data_o, mod_o, hold_d, hold_m);
      end
    end
  end

  // Burst-level model: full words every W bits, then a left-aligned tail if long enough.
  task automatic send_burst(input logic [63:0] data, input int len, input int idle);
    int c0;
    int r;
    exp_t x;
    c0 = cyc;
    for (int j = 0; j < len / W; j++) begin
      x.d = W'(data >> (len - W * (j + 1)));
      x.m = '0;
      x.c = c0 + W * (j + 1);
      sb.push_back(x);
    end
    r = len % W;
    if (r >= 3) begin
      x.d = W'((data & ((64'd1 << r) - 64'd1)) << (W - r));
      x.m = MW'(r);
      x.c = c0 + len + 1;
      sb.push_back(x);
    end
    for (int i = len - 1; i >= 0; i--) begin
      sv = 1'b1;
      sd = data[i];
      @(posedge clk); #1;
      chk("busy_in_burst", 64'(busy_o), 64'(((len - i) % W) != 0));
    end
    sv = 1'b0;
    sd = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_burst", 64'(busy_o), 64'd0);
    repeat (idle) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1;
    sv   = 1'b0;
    sd   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    srst = 1'b0;
    chk("reset_data", 64'(data_o), 64'd0);
    chk("reset_mod",  64'(mod_o),  64'd0);
    chk("reset_val",  64'(val_o),  64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);

    send_burst(64'hA5C3, 16, 2);
    send_burst(64'b10110, 5, 0);
    send_burst(64'b11, 2, 4);
    send_burst(64'b111, 3, 1);
    send_burst(64'h1234FFFF, 32, 1);

    // Reset in the middle of a 7-bit burst discards it.
    for (int i = 0; i < 7; i++) begin
      sv = 1'b1;
      sd = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    srst = 1'b1;
    sv   = 1'b1;
    sd   = 1'b1;
    @(posedge clk); #1;
    srst   = 1'b0;
    sv     = 1'b0;
    sd     = 1'b0;
    hold_d = '0;
    hold_m = '0;
    chk("midreset_data", 64'(data_o), 64'd0);
    chk("midreset_mod",  64'(mod_o),  64'd0);
    chk("midreset_val",  64'(val_o),  64'd0);
    chk("midreset_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    send_burst(64'b0101, 4, 1);

    for (int n = 0; n < 60; n++) begin
      send_burst({32'($urandom), 32'($urandom)}, $urandom_range(1, 16), $urandom_range(0, 3));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
